axi4_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4 read port (AR + R channels) between `NUM_REQ` requesting masters. It sits between several read-issuing masters, such as `axi4_master_bfm` instances, and a single downstream slave, such as `axi4_slave_bfm` on an `axi4_if`. It allows one outstanding burst at a time: it grants one requester, forwards its AR, then routes every R beat to that requester until the `rlast` handshake. Per-requester signals are flattened vectors, with requester k occupying slice k.

---
 rtl/axi4_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) between NUM_REQ masters.
// One outstanding burst at a time; the R channel is routed to the owner until rlast.
module axi4_rd_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_BYTES  = 4,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned NUM_ID_BITS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                s_arvalid,
  output logic [NUM_REQ-1:0]                s_arready,
  input  logic [NUM_REQ*ADDR_BYTES*8-1:0]   s_araddr,
  input  logic [NUM_REQ*8-1:0]              s_arlen,
  input  logic [NUM_REQ*3-1:0]              s_arsize,
  input  logic [NUM_REQ*2-1:0]              s_arburst,
  input  logic [NUM_REQ*NUM_ID_BITS-1:0]    s_arid,
  output logic [NUM_REQ-1:0]                s_rvalid,
  input  logic [NUM_REQ-1:0]                s_rready,
  output logic [DATA_BYTES*8-1:0]           s_rdata,
  output logic [1:0]                        s_rresp,
  output logic                              s_rlast,
  output logic [NUM_ID_BITS-1:0]            s_rid,
  output logic                              m_arvalid,
  output logic [ADDR_BYTES*8-1:0]           m_araddr,
  output logic [7:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic [NUM_ID_BITS-1:0]            m_arid,
  input  logic                              m_arready,
  input  logic                              m_rvalid,
  input  logic [DATA_BYTES*8-1:0]           m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  input  logic [NUM_ID_BITS-1:0]            m_rid,
  output logic                              m_rready,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy
);

  localparam int unsigned AW = ADDR_BYTES * 8;
  localparam int unsigned IW = NUM_ID_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e          state_q, state_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [2:0]      arsize_q, arsize_d;
  logic [1:0]      arburst_q, arburst_d;
  logic [IW-1:0]   arid_q, arid_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  // Rotating search for the first valid requester starting at the priority pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(prio_q) + i) % NUM_REQ);
      if (!win_found && s_arvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    s_arready = '0;
    if (state_q == ST_IDLE && win_found) s_arready[win_idx] = 1'b1;
  end

  // R channel belongs to the granted requester only while a burst is in DATA.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b0;
    if (state_q == ST_DATA) begin
      s_rvalid[grant_q] = m_rvalid;
      m_rready          = s_rready[grant_q];
    end
  end

  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign s_rid     = m_rid;

  assign m_arvalid = (state_q == ST_ADDR);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = arburst_q;
  assign m_arid    = arid_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arid_d    = arid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          araddr_d  = s_araddr[32'(win_idx)*AW +: AW];
          arlen_d   = s_arlen[32'(win_idx)*8 +: 8];
          arsize_d  = s_arsize[32'(win_idx)*3 +: 3];
          arburst_d = s_arburst[32'(win_idx)*2 +: 2];
          arid_d    = s_arid[32'(win_idx)*IW +: IW];
          grant_d   = win_idx;
          prio_d    = IDX_W'((32'(win_idx) + 32'd1) % NUM_REQ);
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_rvalid && m_rready && m_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      prio_q    <= '0;
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arid_q    <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arid_q    <= arid_d;
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter with two requesters and hand-computed expectations.
module tb_axi4_rd_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [7:0]  s_arid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_rvalid, m_rlast, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [3:0]  m_rid;
  logic [0:0]  grant_idx;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;
  int beat;

  axi4_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ar(input int k, input logic [31:0] addr, input logic [7:0] len,
                        input logic [3:0] id);
    s_araddr[k*32 +: 32] = addr;
    s_arlen[k*8 +: 8]    = len;
    s_arsize[k*3 +: 3]   = 3'd2;
    s_arburst[k*2 +: 2]  = 2'd1;
    s_arid[k*4 +: 4]     = id;
  endtask

  initial begin
    aresetn = 1'b0; s_arvalid = '0; s_rready = 2'b11;
    s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arid = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    #2;
    chk("rst_busy",    64'(busy),      64'(0));
    chk("rst_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst_rready",  64'(m_rready),  64'(0));
    chk("rst_srvalid", 64'(s_rvalid),  64'(0));
    chk("rst_grant",   64'(grant_idx), 64'(0));
    chk("rst_araddr",  64'(m_araddr),  64'(0));
    tick(); tick();
    aresetn = 1'b1;

    // Single request from requester 1
    set_ar(1, 32'h40, 8'd3, 4'd5);
    s_arvalid = 2'b10; #1;
    chk("t1_arready", 64'(s_arready), 64'(2'b10));
    tick();
    s_arvalid = 2'b00;
    chk("t1_arvalid", 64'(m_arvalid), 64'(1));
    chk("t1_araddr",  64'(m_araddr),  64'(32'h40));
    chk("t1_arlen",   64'(m_arlen),   64'(3));
    chk("t1_arid",    64'(m_arid),    64'(5));
    chk("t1_grant",   64'(grant_idx), 64'(1));
    chk("t1_busy",    64'(busy),      64'(1));
    chk("t1_noready", 64'(s_arready), 64'(0));
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    chk("t1_arvalid_lo", 64'(m_arvalid), 64'(0));
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA000 + 32'(b); m_rid = 4'd5; m_rlast = (b == 3); #1;
      chk("t1_srvalid", 64'(s_rvalid), 64'(2'b10));
      chk("t1_rdata",   64'(s_rdata),  64'(32'hA000 + 32'(b)));
      chk("t1_rid",     64'(s_rid),    64'(5));
      chk("t1_mrready", 64'(m_rready), 64'(1));
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    chk("t1_busy_lo", 64'(busy), 64'(0));

    // Contention: both requesters, four single-beat bursts, expect 0,1,0,1
    set_ar(0, 32'h1000, 8'd0, 4'd1);
    set_ar(1, 32'h2000, 8'd0, 4'd2);
    s_arvalid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_arready", 64'(s_arready), 64'((g % 2 == 0) ? 2'b01 : 2'b10));
      tick();
      chk("t2_grant",   64'(grant_idx), 64'(g % 2));
      chk("t2_araddr",  64'(m_araddr),  64'((g % 2 == 0) ? 32'h1000 : 32'h2000));
      chk("t2_noready", 64'(s_arready), 64'(0));
      m_arready = 1'b1; tick(); m_arready = 1'b0;
      m_rvalid = 1'b1; m_rlast = 1'b1; #1;
      chk("t2_srvalid", 64'(s_rvalid), 64'((g % 2 == 0) ? 2'b01 : 2'b10));
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
    s_arvalid = 2'b00;

    // AR backpressure on requester 0; stray R traffic must not be forwarded
    set_ar(0, 32'h80, 8'd0, 4'd3);
    s_arvalid = 2'b01; #1;
    tick();
    s_arvalid = 2'b00;
    set_ar(0, 32'hFFFF0000, 8'hFF, 4'hF);
    m_rvalid = 1'b1; m_rlast = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_arvalid", 64'(m_arvalid), 64'(1));
      chk("t3_araddr",  64'(m_araddr),  64'(32'h80));
      chk("t3_arid",    64'(m_arid),    64'(3));
      chk("t3_srvalid", 64'(s_rvalid),  64'(0));
      chk("t3_mrready", 64'(m_rready),  64'(0));
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h55; #1;
    chk("t3_srvalid_data", 64'(s_rvalid), 64'(2'b01));
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // R backpressure: requester 1, 8 beats, owner rready toggling 1,0,1,0
    set_ar(1, 32'h300, 8'd7, 4'd6);
    s_arvalid = 2'b10; #1;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    beat = 0;
    for (int c = 0; c < 15; c++) begin
      s_rready = (c % 2 == 0) ? 2'b11 : 2'b01;
      m_rvalid = 1'b1; m_rdata = 32'hB00 + 32'(beat); m_rlast = (beat == 7); #1;
      chk("t4_mrready", 64'(m_rready), 64'((c % 2 == 0) ? 1 : 0));
      chk("t4_srvalid", 64'(s_rvalid), 64'(2'b10));
      chk("t4_rdata",   64'(s_rdata),  64'(32'hB00 + 32'(beat)));
      if (c % 2 == 0) beat++;
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b11; #1;
    chk("t4_busy_lo", 64'(busy), 64'(0));

    // Error response mid-burst: requester 0, SLVERR on beat 2 of 4
    set_ar(0, 32'h400, 8'd3, 4'd9);
    s_arvalid = 2'b01; #1;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rresp = (b == 1) ? 2'b10 : 2'b00; m_rlast = (b == 3); #1;
      chk("t5_rresp", 64'(s_rresp), 64'((b == 1) ? 2'b10 : 2'b00));
      chk("t5_rlast", 64'(s_rlast), 64'((b == 3) ? 1 : 0));
      chk("t5_busy",  64'(busy),    64'(1));
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; #1;
    chk("t5_busy_lo", 64'(busy), 64'(0));

    // Reset during beat 2 of 8 on requester 1
    set_ar(1, 32'h500, 8'd7, 4'd4);
    s_arvalid = 2'b10; #1;
    tick();
    s_arvalid = 2'b00;
    chk("t6_grant_pre", 64'(grant_idx), 64'(1));
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0; #1;
    tick();
    #1;
    chk("t6_srvalid_pre", 64'(s_rvalid), 64'(2'b10));
    aresetn = 1'b0; #1;
    chk("t6_mrready", 64'(m_rready),  64'(0));
    chk("t6_srvalid", 64'(s_rvalid),  64'(0));
    chk("t6_arvalid", 64'(m_arvalid), 64'(0));
    chk("t6_busy",    64'(busy),      64'(0));
    chk("t6_grant",   64'(grant_idx), 64'(0));
    m_rvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    s_arvalid = 2'b11; #1;
    chk("t6_arready_post", 64'(s_arready), 64'(2'b01));
    tick();
    s_arvalid = 2'b00;
    chk("t6_grant_post", 64'(grant_idx), 64'(0));
    chk("t6_busy_post",  64'(busy),      64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
